// File: rtl/intra4x4_pred_mode_ctx_if.sv
// Handshake and context bus between the mode decoder side and the
// Intra4x4 prediction-mode neighbour-context store.
interface intra4x4_pred_mode_ctx_if #(
  parameter int MB_X_BITS = 7
) ();
  logic                 slice_start;
  logic                 mb_start;
  logic [MB_X_BITS-1:0] mb_x_in;
  logic                 mb_is_i4x4;
  logic                 mode_valid;
  logic [3:0]           blk_idx_in;
  logic [3:0]           mode_in;
  logic                 mb_done;
  logic [15:0]          intra4x4_pred_mode_up_mb_out;
  logic [15:0]          intra4x4_pred_mode_left_mb_out;
  logic [63:0]          intra4x4_pred_mode_curr_mb_out;
  logic                 ctx_valid;
  logic                 idle;

  modport master (
    output slice_start, mb_start, mb_x_in, mb_is_i4x4,
           mode_valid, blk_idx_in, mode_in, mb_done,
    input  intra4x4_pred_mode_up_mb_out, intra4x4_pred_mode_left_mb_out,
           intra4x4_pred_mode_curr_mb_out, ctx_valid, idle
  );

  modport slave (
    input  slice_start, mb_start, mb_x_in, mb_is_i4x4,
           mode_valid, blk_idx_in, mode_in, mb_done,
    output intra4x4_pred_mode_up_mb_out, intra4x4_pred_mode_left_mb_out,
           intra4x4_pred_mode_curr_mb_out, ctx_valid, idle
  );
endinterface

// File: rtl/intra4x4_pred_mode_ctx.sv
// Neighbour-context store for Intra4x4 prediction-mode decoding.
// Holds current-MB modes, the left MB's right column and a line buffer of
// bottom-row modes per MB column; commits neighbour context at MB end.
// Optional protocol checker with sticky err output: INTRA4X4_MODE_CTX_ERR_EN.
//
// state  | meaning
// IDLE   | waiting for mb_start; line-buffer read issued on accept
// LOAD   | read data registered into up_mb
// ACTIVE | context valid; decoded modes captured into curr_mb
// COMMIT | line buffer and left register updated from curr_mb
module intra4x4_pred_mode_ctx #(
  parameter int LINE_DEPTH = 120,
  parameter int MB_X_BITS  = 7
) (
  input  logic                   clk,
  input  logic                   reset_n,
  intra4x4_pred_mode_ctx_if.slave ctx
`ifdef INTRA4X4_MODE_CTX_ERR_EN
  ,
  output logic                   err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_ACTIVE = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [MB_X_BITS-1:0] mb_x_q;
  logic                 is_i4_q;
  logic [15:0]          rd_data;
  logic [15:0]          up_q;
  logic [15:0]          left_q;
  logic [63:0]          curr_q;
  logic [15:0]          line_mem [LINE_DEPTH];

  logic                 mb_accept;
  logic                 slice_accept;
  logic                 mode_wr;
  logic [5:0]           wr_lsb;
  logic [15:0]          line_wdata;
  logic [15:0]          left_wdata;

  assign mb_accept    = (state_q == S_IDLE) && ctx.mb_start;
  assign slice_accept = (state_q == S_IDLE) && ctx.slice_start;
  assign mode_wr      = (state_q == S_ACTIVE) && ctx.mode_valid && is_i4_q;
  assign wr_lsb       = {ctx.blk_idx_in, 2'b00};

  // bottom row of the MB feeds the next row; right column feeds the next MB
  assign line_wdata = {curr_q[63:60], curr_q[59:56], curr_q[47:44], curr_q[43:40]};
  assign left_wdata = {curr_q[63:60], curr_q[55:52], curr_q[31:28], curr_q[23:20]};

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (ctx.mb_start) state_d = S_LOAD;
      S_LOAD:   state_d = S_ACTIVE;
      S_ACTIVE: if (ctx.mb_done) state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // single-port line buffer: read on accepted mb_start, write in COMMIT; not reset
  always_ff @(posedge clk) begin
    if (mb_accept) rd_data <= line_mem[ctx.mb_x_in];
    if (state_q == S_COMMIT) line_mem[mb_x_q] <= line_wdata;
  end

  // per-MB attributes latched at start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mb_x_q  <= '0;
      is_i4_q <= 1'b0;
    end else if (mb_accept) begin
      mb_x_q  <= ctx.mb_x_in;
      is_i4_q <= ctx.mb_is_i4x4;
    end
  end

  // above-MB context, loaded from the line-buffer read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 up_q <= '0;
    else if (state_q == S_LOAD)   up_q <= rd_data;
  end

  // left-MB context: DC default at slice start, right column at commit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                   left_q <= 16'h2222;
    else if (slice_accept)          left_q <= 16'h2222;
    else if (state_q == S_COMMIT)   left_q <= left_wdata;
  end

  // current-MB modes: cleared (I4x4) or DC-filled at start, captured per block
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       curr_q <= '0;
    else if (mb_accept) curr_q <= ctx.mb_is_i4x4 ? 64'h0 : 64'h2222_2222_2222_2222;
    else if (mode_wr)   curr_q[wr_lsb +: 4] <= ctx.mode_in;
  end

  assign ctx.intra4x4_pred_mode_up_mb_out   = up_q;
  assign ctx.intra4x4_pred_mode_left_mb_out = left_q;
  assign ctx.intra4x4_pred_mode_curr_mb_out = curr_q;
  assign ctx.ctx_valid = (state_q == S_ACTIVE);
  assign ctx.idle      = (state_q == S_IDLE);

`ifdef INTRA4X4_MODE_CTX_ERR_EN
  logic [15:0] wr_mask;
  logic        viol;

  // a block already written this MB is a duplicate write
  assign viol = (ctx.mode_valid && (state_q != S_ACTIVE))
             || (ctx.mode_valid && (ctx.mode_in > 4'd8))
             || (ctx.mb_start && (state_q != S_IDLE))
             || (ctx.mb_done && (state_q != S_ACTIVE))
             || (ctx.mode_valid && (state_q == S_ACTIVE) && wr_mask[ctx.blk_idx_in]);

  // written-block mask, cleared at each accepted MB start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      wr_mask <= '0;
    else if (mb_accept)
      wr_mask <= '0;
    else if ((state_q == S_ACTIVE) && ctx.mode_valid)
      wr_mask[ctx.blk_idx_in] <= 1'b1;
  end

  // sticky error flag, cleared only by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  err <= 1'b0;
    else if (viol) err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_intra4x4_pred_mode_ctx.sv
// Self-checking bench for intra4x4_pred_mode_ctx: directed cases plus
// randomized macroblocks checked against an array-based reference model.
module tb_intra4x4_pred_mode_ctx;
  localparam int LD = 120;
  localparam int XB = 7;

  logic clk = 1'b0;
  logic reset_n;
`ifdef INTRA4X4_MODE_CTX_ERR_EN
  logic err;
`endif

  intra4x4_pred_mode_ctx_if #(.MB_X_BITS(XB)) ctx ();

  intra4x4_pred_mode_ctx #(.LINE_DEPTH(LD), .MB_X_BITS(XB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ctx     (ctx)
`ifdef INTRA4X4_MODE_CTX_ERR_EN
    ,
    .err     (err)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model: modes per block, per-column bottom rows, left column
  int          cur_m [16];
  bit          cur_i4;
  int          cur_x;
  logic [15:0] line_m  [LD];
  bit          line_ok [LD];
  logic [15:0] left_m;

  function automatic logic [63:0] pack_cur();
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < 16; k++) v[4*k +: 4] = 4'(cur_m[k]);
    return v;
  endfunction

  function automatic logic [15:0] pick4(int a, int b, int c, int d);
    return {4'(cur_m[a]), 4'(cur_m[b]), 4'(cur_m[c]), 4'(cur_m[d])};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    ctx.slice_start = 0; ctx.mb_start = 0; ctx.mb_x_in = '0; ctx.mb_is_i4x4 = 0;
    ctx.mode_valid = 0; ctx.blk_idx_in = '0; ctx.mode_in = '0; ctx.mb_done = 0;
  endtask

  task automatic start_mb(input int x, input bit i4, input bit slice);
    ctx.mb_start = 1; ctx.mb_x_in = XB'(x); ctx.mb_is_i4x4 = i4; ctx.slice_start = slice;
    tick();
    clear_in();
    if (slice) left_m = 16'h2222;
    for (int k = 0; k < 16; k++) cur_m[k] = i4 ? 0 : 2;
    cur_i4 = i4;
    cur_x  = x;
    chk("load_idle", ctx.idle, 1'b0);
    chk("load_ctx_valid", ctx.ctx_valid, 1'b0);
    tick();
    chk("active_ctx_valid", ctx.ctx_valid, 1'b1);
    chk("active_left", ctx.intra4x4_pred_mode_left_mb_out, left_m);
    chk("active_curr", ctx.intra4x4_pred_mode_curr_mb_out, pack_cur());
    if (line_ok[x]) chk("active_up", ctx.intra4x4_pred_mode_up_mb_out, line_m[x]);
  endtask

  // called right after the edge that accepted mb_done
  task automatic after_done();
    chk("commit_ctx_valid", ctx.ctx_valid, 1'b0);
    chk("commit_idle", ctx.idle, 1'b0);
    line_m[cur_x]  = pick4(15, 14, 11, 10);
    line_ok[cur_x] = 1;
    left_m         = pick4(15, 13, 7, 5);
    tick();
    chk("post_idle", ctx.idle, 1'b1);
    chk("post_left", ctx.intra4x4_pred_mode_left_mb_out, left_m);
    chk("post_curr_hold", ctx.intra4x4_pred_mode_curr_mb_out, pack_cur());
  endtask

  task automatic write_mode(input int blk, input int mode, input bit done);
    ctx.mode_valid = 1; ctx.blk_idx_in = 4'(blk); ctx.mode_in = 4'(mode); ctx.mb_done = done;
    tick();
    clear_in();
    if (cur_i4) cur_m[blk] = mode;
    chk("curr_write", ctx.intra4x4_pred_mode_curr_mb_out, pack_cur());
    if (done) after_done();
  endtask

  task automatic end_mb();
    ctx.mb_done = 1;
    tick();
    clear_in();
    after_done();
  endtask

  initial begin
    clear_in();
    for (int i = 0; i < LD; i++) line_ok[i] = 0;
    left_m = 16'h2222;
    reset_n = 0;
    tick(); tick();
    chk("rst_up", ctx.intra4x4_pred_mode_up_mb_out, 16'h0);
    chk("rst_left", ctx.intra4x4_pred_mode_left_mb_out, 16'h2222);
    chk("rst_curr", ctx.intra4x4_pred_mode_curr_mb_out, 64'h0);
    reset_n = 1;
    tick();
    chk("rst_idle", ctx.idle, 1'b1);
    chk("rst_ctx_valid", ctx.ctx_valid, 1'b0);
`ifdef INTRA4X4_MODE_CTX_ERR_EN
    chk("rst_err", err, 1'b0);
`endif

    // single I4x4 MB at x=3, mode = blk % 9
    start_mb(3, 1, 1);
    for (int b = 0; b < 16; b++) write_mode(b, b % 9, 0);
    chk("single_curr_const", ctx.intra4x4_pred_mode_curr_mb_out, 64'h6543_2108_7654_3210);
    end_mb();
    start_mb(4, 1, 0);
    chk("single_left_const", ctx.intra4x4_pred_mode_left_mb_out, 16'h6475);
    end_mb();
    start_mb(3, 1, 0);
    chk("next_row_up_const", ctx.intra4x4_pred_mode_up_mb_out, 16'h6521);
    end_mb();

    // non-I4x4 MB: writes ignored, commits all 2s
    start_mb(0, 0, 0);
    write_mode(5, 7, 0);
    write_mode(15, 1, 0);
    chk("non_i4_curr", ctx.intra4x4_pred_mode_curr_mb_out, 64'h2222_2222_2222_2222);
    end_mb();
    chk("non_i4_left", ctx.intra4x4_pred_mode_left_mb_out, 16'h2222);
    start_mb(0, 1, 0);
    chk("non_i4_up", ctx.intra4x4_pred_mode_up_mb_out, 16'h2222);
    end_mb();

    // mode_valid for blk15 together with mb_done
    start_mb(5, 1, 0);
    write_mode(15, 7, 1);
    start_mb(6, 1, 0);
    chk("simul_left_msn", 64'(ctx.intra4x4_pred_mode_left_mb_out[15:12]), 64'h7);
    end_mb();
    start_mb(5, 1, 0);
    chk("simul_up_msn", 64'(ctx.intra4x4_pred_mode_up_mb_out[15:12]), 64'h7);
    end_mb();

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      start_mb($urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0);
      for (int b = 0; b < 15; b++)
        if ($urandom_range(0, 1) == 1) write_mode(b, $urandom_range(0, 8), 0);
      if ($urandom_range(0, 1) == 1) write_mode(15, $urandom_range(0, 8), 1);
      else end_mb();
      repeat ($urandom_range(0, 2)) tick();
    end
`ifdef INTRA4X4_MODE_CTX_ERR_EN
    chk("clean_err", err, 1'b0);
    start_mb(1, 1, 0);
    write_mode(0, 9, 0);
    chk("err_set", err, 1'b1);
    tick(); tick();
    chk("err_hold", err, 1'b1);
    reset_n = 0;
    #1;
    chk("err_reset", err, 1'b0);
    reset_n = 1;
    left_m = 16'h2222;
    tick();
`endif

    // mb_start while ACTIVE is ignored
    start_mb(2, 1, 0);
    write_mode(3, 4, 0);
    ctx.mb_start = 1; ctx.mb_x_in = XB'(7); ctx.mb_is_i4x4 = 0; ctx.slice_start = 1;
    tick();
    clear_in();
    chk("abuse_ctx_valid", ctx.ctx_valid, 1'b1);
    chk("abuse_curr", ctx.intra4x4_pred_mode_curr_mb_out, pack_cur());
    chk("abuse_left", ctx.intra4x4_pred_mode_left_mb_out, left_m);
    end_mb();

    // reset while ACTIVE: immediate return to reset values
    start_mb(2, 1, 0);
    write_mode(9, 5, 0);
    reset_n = 0;
    #1;
    chk("midrst_idle", ctx.idle, 1'b1);
    chk("midrst_ctx_valid", ctx.ctx_valid, 1'b0);
    chk("midrst_up", ctx.intra4x4_pred_mode_up_mb_out, 16'h0);
    chk("midrst_left", ctx.intra4x4_pred_mode_left_mb_out, 16'h2222);
    chk("midrst_curr", ctx.intra4x4_pred_mode_curr_mb_out, 64'h0);
    tick();
    reset_n = 1;
    left_m = 16'h2222;
    tick();
    start_mb(2, 1, 0);
    end_mb();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
